// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: FSM state encodings,
// transaction owner codes, default bus widths and the starvation counter width.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    // Width of the consecutive-fetch-loss counter; STARVE_LIMIT must fit in it.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// arb_starve_cnt
// Counts how many times in a row the fetch unit lost arbitration to a data
// request. Saturates at its maximum value; limit_hit tells the arbiter that
// the next grant must go to fetch.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   inc       in   data captured while fetch was also requesting
//   clr       in   fetch captured
//   limit_hit out  count has reached LIMIT
// ----------------------------------------------------------------------------
module arb_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_hit = (cnt >= CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single memory port between the fetch unit (instruction reads)
// and the control unit (data reads/writes). One transaction is outstanding at
// a time; data wins arbitration unless fetch has lost STARVE_LIMIT times in a
// row. All outputs are registered.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   f_req/f_addr                  fetch read request (held until f_gnt)
//   f_gnt/f_rvalid/f_rdata        fetch grant pulse, response pulse and data
//   d_req/d_we/d_addr/d_wdata     data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata        data grant pulse, response pulse and data
//                                 (d_rdata is 0 on write completion)
//   m_req/m_we/m_addr/m_wdata     memory request, held until m_ack
//   m_ack/m_rvalid/m_rdata        memory accept, response pulse and read data
//   err_spurious                  sticky: m_rvalid with no accepted transaction
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          err_spurious
);

    state_t state;
    owner_t owner;
    logic   limit_hit;
    logic   take_data;
    logic   take_fetch;
    logic   resp_done;

    // Data wins unless fetch is also waiting and has already lost too often.
    assign take_data  = (state == ST_IDLE) && d_req && (!f_req || !limit_hit);
    assign take_fetch = (state == ST_IDLE) && f_req && !take_data;

    // The response completes either in WAIT, or in ISSUE when the memory
    // accepts and answers in the same cycle.
    assign resp_done  = ((state == ST_ISSUE) && m_ack && m_rvalid) ||
                        ((state == ST_WAIT)  && m_rvalid);

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (take_data && f_req),
        .clr       (take_fetch),
        .limit_hit (limit_hit)
    );

    // The m_we/m_addr/m_wdata outputs double as the capture registers; they
    // hold the last captured transaction until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= OWN_FETCH;
            f_gnt        <= 1'b0;
            f_rvalid     <= 1'b0;
            f_rdata      <= '0;
            d_gnt        <= 1'b0;
            d_rvalid     <= 1'b0;
            d_rdata      <= '0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            err_spurious <= 1'b0;
        end else begin
            // Grant and response strobes are single-cycle pulses.
            f_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            if (m_rvalid && ((state == ST_IDLE) || ((state == ST_ISSUE) && !m_ack))) begin
                err_spurious <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (take_data) begin
                        owner   <= OWN_DATA;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        d_gnt   <= 1'b1;
                        m_req   <= 1'b1;
                        state   <= ST_ISSUE;
                    end else if (take_fetch) begin
                        owner   <= OWN_FETCH;
                        m_we    <= 1'b0;
                        m_addr  <= f_addr;
                        m_wdata <= '0;
                        f_gnt   <= 1'b1;
                        m_req   <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= m_rvalid ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Route the response to the owner; rdata holds between responses.
            if (resp_done) begin
                if (owner == OWN_FETCH) begin
                    f_rvalid <= 1'b1;
                    f_rdata  <= m_rdata;
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= m_we ? '0 : m_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Requester drivers hold each
// request until its grant, a memory responder answers with programmable
// ack/response delays, and a transaction-level model predicts every output
// each cycle. Directed tests add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          f_req, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we, m_ack, m_rvalid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          err_spurious;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_gnt        (f_gnt),
        .f_rvalid     (f_rvalid),
        .f_rdata      (f_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_ack        (m_ack),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .err_spurious (err_spurious)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] outs();
        return {57'd0, f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
                m_req, m_we, m_addr, m_wdata, err_spurious};
    endfunction

    // ------------------------------------------------------------------
    // Requester drivers: hold the head request until its grant is seen,
    // then move on in the cycle after the grant.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dreq_t;

    logic [AW-1:0] fq[$];
    dreq_t         dq[$];

    task automatic push_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        dreq_t r;
        r.we    = we;
        r.addr  = a;
        r.wdata = wd;
        dq.push_back(r);
    endtask

    initial begin : fetch_drv
        bit seen;
        f_req  = 1'b0;
        f_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (seen && fq.size() > 0) void'(fq.pop_front());
            f_req = (fq.size() > 0);
            if (fq.size() > 0) f_addr = fq[0];
            @(negedge clk);
            seen = f_gnt;
        end
    end

    initial begin : data_drv
        bit seen;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (seen && dq.size() > 0) void'(dq.pop_front());
            d_req = (dq.size() > 0);
            if (dq.size() > 0) begin
                d_we    = dq[0].we;
                d_addr  = dq[0].addr;
                d_wdata = dq[0].wdata;
            end
            @(negedge clk);
            seen = d_gnt;
        end
    end

    // ------------------------------------------------------------------
    // Memory responder with programmable delays. ack_delay = cycles of
    // m_req before m_ack; rv_delay = cycles from m_ack to m_rvalid.
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            ack_delay   = 0;
    int            rv_delay    = 1;
    bit            inject_spur = 1'b0;

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5A5A);
    endfunction

    initial begin : responder
        bit            r_acked;
        bit            r_we;
        int            r_cnt;
        logic [AW-1:0] r_addr;
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            m_ack    = 1'b0;
            m_rvalid = 1'b0;
            if (rst) begin
                r_acked = 1'b0;
                r_cnt   = 0;
            end else if (inject_spur) begin
                m_rvalid    = 1'b1;
                m_rdata     = 16'h0BAD;
                inject_spur = 1'b0;
            end else if (m_req && !r_acked) begin
                if (r_cnt == ack_delay) begin
                    m_ack   = 1'b1;
                    r_acked = 1'b1;
                    r_cnt   = 0;
                    r_we    = m_we;
                    r_addr  = m_addr;
                    if (m_we) mem[m_addr] = m_wdata;
                    if (rv_delay == 0) begin
                        m_rvalid = 1'b1;
                        m_rdata  = r_we ? 16'hDEAD : rd(r_addr);
                        r_acked  = 1'b0;
                    end
                end else begin
                    r_cnt++;
                end
            end else if (r_acked) begin
                r_cnt++;
                if (r_cnt == rv_delay) begin
                    m_rvalid = 1'b1;
                    m_rdata  = r_we ? 16'hDEAD : rd(r_addr);
                    r_acked  = 1'b0;
                    r_cnt    = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level model and per-cycle compare. Each negedge checks
    // the outputs predicted last cycle, then predicts the next cycle from
    // the arbitration rules and what the memory side did this cycle.
    // ------------------------------------------------------------------
    byte gnt_log[$];

    initial begin : model
        bit            busy, acked, own_data, we_c, done;
        int            losses;
        logic [AW-1:0] addr_c, e_madr;
        logic [DW-1:0] wd_c, e_frd, e_drd, e_mwd;
        logic          e_fg, e_fv, e_dg, e_dv, e_mreq, e_mwe, e_err;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; acked = 0; losses = 0;
                e_fg = 0; e_fv = 0; e_dg = 0; e_dv = 0;
                e_mreq = 0; e_mwe = 0; e_err = 0;
                e_frd = '0; e_drd = '0; e_madr = '0; e_mwd = '0;
            end else begin
                check("cycle_outputs", outs(),
                      {57'd0, e_fg, e_fv, e_frd, e_dg, e_dv, e_drd,
                       e_mreq, e_mwe, e_madr, e_mwd, e_err});
                if (f_gnt) gnt_log.push_back(8'h46);
                if (d_gnt) gnt_log.push_back(8'h44);

                e_fg = 0; e_dg = 0; e_fv = 0; e_dv = 0;
                if (m_rvalid && (!busy || (!acked && !m_ack))) e_err = 1;

                if (!busy) begin
                    if (d_req && (!f_req || losses < LIMIT)) begin
                        busy = 1; acked = 0; own_data = 1;
                        we_c = d_we; addr_c = d_addr; wd_c = d_wdata;
                        e_dg = 1;
                        if (f_req && losses < 15) losses++;
                    end else if (f_req) begin
                        busy = 1; acked = 0; own_data = 0;
                        we_c = 0; addr_c = f_addr; wd_c = '0;
                        e_fg = 1;
                        losses = 0;
                    end
                    if (busy) begin
                        e_mreq = 1; e_mwe = we_c; e_madr = addr_c; e_mwd = wd_c;
                    end
                end else begin
                    done = 0;
                    if (!acked) begin
                        if (m_ack) begin
                            acked  = 1;
                            e_mreq = 0;
                            done   = m_rvalid;
                        end
                    end else begin
                        done = m_rvalid;
                    end
                    if (done) begin
                        busy = 0;
                        if (own_data) begin
                            e_dv  = 1;
                            e_drd = we_c ? '0 : m_rdata;
                        end else begin
                            e_fv  = 1;
                            e_frd = m_rdata;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    task automatic wait_for(input int sel, input int budget, input string nm);
        int n   = 0;
        bit hit = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = f_gnt;
                1:       hit = d_gnt;
                2:       hit = f_rvalid;
                default: hit = d_rvalid;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, got no event within %0d cycles", nm, budget);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        string exp_seq;
        int    base, n, m;

        mem[16'h0010] = 16'hBEEF;
        #2;
        check("reset_state", outs(), 128'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single fetch
        fq.push_back(16'h0010);
        wait_for(0, 20, "t1_f_gnt");
        check("t1_m_req",  m_req,  1'b1);
        check("t1_m_addr", m_addr, 16'h0010);
        check("t1_m_we",   m_we,   1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t1_f_rvalid", f_rvalid, 1'b1);
        check("t1_f_rdata",  f_rdata,  16'hBEEF);
        check("t1_d_quiet",  {d_gnt, d_rvalid, d_rdata}, 18'd0);

        // Simultaneous requests: data write goes first, then fetch
        fq.push_back(16'h0030);
        push_d(1'b1, 16'h0020, 16'h1234);
        wait_for(1, 20, "t2_d_gnt");
        check("t2_f_gnt_low", f_gnt,   1'b0);
        check("t2_m_we",      m_we,    1'b1);
        check("t2_m_addr",    m_addr,  16'h0020);
        check("t2_m_wdata",   m_wdata, 16'h1234);
        wait_for(3, 20, "t2_d_rvalid");
        check("t2_d_rdata_wr", d_rdata, 16'h0000);
        wait_for(0, 20, "t2_f_gnt");
        check("t2_f_addr", m_addr, 16'h0030);
        wait_for(2, 20, "t2_f_rvalid");
        check("t2_f_rdata", f_rdata, 16'h5A6A);
        push_d(1'b0, 16'h0020, 16'h0000);
        wait_for(3, 20, "t2_rd_back");
        check("t2_rd_back_data", d_rdata, 16'h1234);

        // Starvation guard: both sides held continuously
        repeat (2) @(negedge clk);
        base = gnt_log.size();
        for (int i = 0; i < 9; i++) push_d(1'b0, 16'h0100 + 16'(i), 16'h0000);
        fq.push_back(16'h0200);
        fq.push_back(16'h0201);
        n = 0;
        while (gnt_log.size() < base + 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        exp_seq = "DDDDFDDDDF";
        for (int i = 0; i < 10; i++) begin
            if (gnt_log.size() > base + i)
                check($sformatf("t3_grant_%0d", i), gnt_log[base + i], exp_seq[i]);
            else
                check($sformatf("t3_grant_%0d", i), 8'h00, exp_seq[i]);
        end
        n = 0;
        while ((dq.size() > 0 || fq.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);

        // Stalled memory: 5-cycle ack delay, 7-cycle response delay
        ack_delay = 5;
        rv_delay  = 7;
        push_d(1'b0, 16'h0055, 16'h0000);
        wait_for(1, 20, "t4_d_gnt");
        n = 0;
        while (m_req && n < 20) begin
            check("t4_addr_stable", m_addr, 16'h0055);
            n++;
            @(negedge clk);
        end
        check("t4_mreq_cycles", n, 6);
        m = 0;
        while (!d_rvalid && m < 30) begin
            check("t4_no_mreq", m_req, 1'b0);
            @(negedge clk);
            m++;
        end
        check("t4_rvalid_gap", m, 7);
        check("t4_d_rdata", d_rdata, 16'h5A0F);
        ack_delay = 0;

        // Same-cycle ack and response, then a spurious response
        rv_delay = 0;
        fq.push_back(16'h0066);
        wait_for(0, 20, "t5_f_gnt");
        @(negedge clk);
        check("t5_f_rvalid", f_rvalid, 1'b1);
        check("t5_f_rdata",  f_rdata,  16'h5A3C);
        rv_delay = 1;
        repeat (2) @(negedge clk);
        check("t5_err_clear", err_spurious, 1'b0);
        inject_spur = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_err_set", err_spurious, 1'b1);
        push_d(1'b1, 16'h0070, 16'h00AA);
        wait_for(3, 20, "t5_d_rvalid");
        check("t5_err_sticky", err_spurious, 1'b1);

        // Reset while waiting for a response
        rv_delay = 10;
        repeat (2) @(negedge clk);
        fq.push_back(16'h0077);
        wait_for(0, 20, "t6_f_gnt");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("t6_async_clear", outs(), 128'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        rv_delay = 1;
        repeat (2) @(negedge clk);
        fq.push_back(16'h0040);
        wait_for(0, 20, "t6_f_gnt_after");
        wait_for(2, 20, "t6_f_rvalid_after");
        check("t6_f_rdata", f_rdata, 16'h5A1A);
        check("t6_err_after", err_spurious, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
